// File: rtl/rca_pkg.sv
// Shared constants and types for the ripple-carry adder.
// The latency constant tracks the RCA_INPUT_REG_EN build option.
package rca_pkg;

  localparam int RCA_DEFAULT_WIDTH = 100;

  typedef logic [RCA_DEFAULT_WIDTH-1:0] rca_vec_t;

`ifdef RCA_INPUT_REG_EN
  localparam int RCA_LATENCY = 2;
`else
  localparam int RCA_LATENCY = 1;
`endif

endpackage : rca_pkg

// File: rtl/rca_100bit_adder_full_adder.sv
// Single-bit full adder: the cell the ripple chain is built from.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/rca_100bit_adder.sv
// Registered ripple-carry adder exposing the per-bit carry vector.
// Build option RCA_INPUT_REG_EN adds an input flop stage (latency 2 instead of 1).
module rca_100bit_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout
);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             op_valid;

`ifdef RCA_INPUT_REG_EN
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic             in_valid_q, in_valid_d;

  always_comb begin
    a_d        = a;
    b_d        = b;
    cin_d      = cin;
    in_valid_d = in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      in_valid_q <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      in_valid_q <= in_valid_d;
    end
  end

  assign op_a     = a_q;
  assign op_b     = b_q;
  assign op_cin   = cin_q;
  assign op_valid = in_valid_q;
`else
  assign op_a     = a;
  assign op_b     = b;
  assign op_cin   = cin;
  assign op_valid = in_valid;
`endif

  // carry_chain[i] is the carry into bit i; carry_chain[i+1] its carry out.
  logic [WIDTH:0]   carry_chain;
  logic [WIDTH-1:0] s_comb;

  assign carry_chain[0] = op_cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (op_a[i]),
      .b    (op_b[i]),
      .cin  (carry_chain[i]),
      .s    (s_comb[i]),
      .cout (carry_chain[i+1])
    );
  end

  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] cout_q, cout_d;
  logic             out_valid_q, out_valid_d;

  always_comb begin
    sum_d       = s_comb;
    cout_d      = carry_chain[WIDTH:1];
    out_valid_d = op_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule : rca_100bit_adder

// File: tb/tb_rca_100bit_adder.sv
// Self-checking bench for rca_100bit_adder; reference is plain a + b + cin arithmetic.
module tb_rca_100bit_adder;
  import rca_pkg::*;

  localparam int W   = RCA_DEFAULT_WIDTH;
  localparam int LAT = RCA_LATENCY;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic [W-1:0] sum, cout;

  rca_100bit_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic [W-1:0] cout;
    logic         valid;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Carry out of bit i is the carry into bit i+1, recovered from the exact
  // wide sum as full[i+1] ^ a[i+1] ^ b[i+1]; the top carry is full[W].
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input logic mv);
    exp_t         e;
    logic [W:0]   full;
    logic [W:0]   xa, xb;
    full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
    xa   = {1'b0, ma};
    xb   = {1'b0, mb};
    for (int i = 0; i < W; i++) e.cout[i] = full[i+1] ^ xa[i+1] ^ xb[i+1];
    e.sum   = full[W-1:0];
    e.valid = mv;
    return e;
  endfunction

  task automatic check_outputs(input string tag, input logic [W-1:0] es,
                               input logic [W-1:0] ec, input logic ev);
    checks++;
    assert (sum === es) else begin
      errors++;
      $error("FAIL %s sum: got %h expected %h", tag, sum, es);
    end
    checks++;
    assert (cout === ec) else begin
      errors++;
      $error("FAIL %s cout: got %h expected %h", tag, cout, ec);
    end
    checks++;
    assert (out_valid === ev) else begin
      errors++;
      $error("FAIL %s out_valid: got %b expected %b", tag, out_valid, ev);
    end
  endtask

  // One clock: drive at negedge, queue the expected result, check after posedge.
  task automatic step(input string tag, input logic [W-1:0] sa, input logic [W-1:0] sb,
                      input logic sc, input logic sv);
    exp_t e;
    @(negedge clk);
    a = sa; b = sb; cin = sc; in_valid = sv;
    exp_q.push_back(model(sa, sb, sc, sv));
    @(posedge clk);
    #1;
    if (exp_q.size() >= LAT) begin
      e = exp_q.pop_front();
      check_outputs(tag, e.sum, e.cout, e.valid);
    end
  endtask

  task automatic flush(input string tag);
    for (int i = 0; i < LAT; i++) step(tag, '0, '0, 1'b0, 1'b0);
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  logic [W-1:0] ones;
  logic [W-1:0] ra, rb;

  initial begin
    ones = '1;
    rst_n = 1'b0;
    a = ones; b = ones; cin = 1'b1; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset_hold", '0, '0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    step("add_5_10", W'(5), W'(10), 1'b0, 1'b1);
    flush("add_5_10_flush");
    step("add_27_45", W'(27), W'(45), 1'b0, 1'b1);
    step("add_77_18", W'(77), W'(18), 1'b0, 1'b1);
    step("cin_only", '0, '0, 1'b1, 1'b1);
    step("ripple_ones_plus_cin", ones, '0, 1'b1, 1'b1);
    step("ones_plus_ones_cin", ones, ones, 1'b1, 1'b1);
    step("valid_pat_1", W'(100), W'(200), 1'b0, 1'b1);
    step("valid_pat_0", W'(7), W'(9), 1'b1, 1'b0);
    step("valid_pat_1b", ones, W'(1), 1'b0, 1'b1);
    flush("pattern_flush");

    // Directed constants cross-checking the model itself against known answers.
    begin
      exp_t e;
      e = model(W'(27), W'(45), 1'b0, 1'b1);
      checks++;
      assert (e.sum === W'(72) && e.cout === W'(63)) else begin
        errors++;
        $error("FAIL model_27_45: got sum %0d cout %0d expected 72 63", e.sum, e.cout);
      end
    end

    // Async reset between clocks with a nonzero result held.
    step("pre_reset", ones, ones, 1'b1, 1'b1);
    flush("pre_reset_flush_fill");
    step("pre_reset_live", ones, W'(3), 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", '0, '0, 1'b0);
    exp_q.delete();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step("post_reset_first", W'(1), W'(2), 1'b0, 1'b1);
    flush("post_reset_flush");

    for (int n = 0; n < 40; n++) begin
      ra = rand_vec();
      rb = rand_vec();
      step("random", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    flush("random_flush");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rca_100bit_adder
